window_writer: RTL and testbench

- Write-side counterpart of the windowed selector: the selector extracts K-bit windows from a flat vector at bit offsets; this block builds that flat vector.
- It accepts K serial (offset, K-bit word) writes and deposits each word into a SIZE-bit buffer at the given bit offset.
- After K writes it presents the assembled buffer to the downstream selector stage with a valid/ready handshake.

---
 rtl/window_writer_if.sv | 37 +++
 rtl/window_writer.sv | 94 +++++++++
 tb/tb_window_writer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/window_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : window_writer_if
//  Purpose  : Write-port / frame-output bundle for window_writer. The master
//             side issues (offset, word) writes and consumes frames; the
//             slave side is the frame assembler.
//  Revision : 1.0 - initial release
// ============================================================================
interface window_writer_if #(
    parameter int SIZE = 16,
    parameter int K    = 4
);
    localparam int AW = $clog2(SIZE);
    localparam int CW = $clog2(K + 1);

    logic            clear;
    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   in_addr;
    logic [K-1:0]    in_data;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] buffer_flat;
    logic [CW-1:0]   write_count;
    logic            trunc;

    modport master (
        output clear, in_valid, in_addr, in_data, out_ready,
        input  in_ready, out_valid, buffer_flat, write_count, trunc
    );

    modport slave (
        input  clear, in_valid, in_addr, in_data, out_ready,
        output in_ready, out_valid, buffer_flat, write_count, trunc
    );
endinterface
`default_nettype wire

// File: rtl/window_writer.sv
`default_nettype none
// ============================================================================
//  Module   : window_writer
//  Purpose  : Assembles a SIZE-bit flat buffer from K writes of K-bit words
//             placed at arbitrary bit offsets, then hands the frame downstream
//             with a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module window_writer #(
    parameter int SIZE = 16,
    parameter int K    = 4
) (
    input  wire             clk,
    input  wire             rst,
    window_writer_if.slave  bus
);
    localparam int AW = $clog2(SIZE);
    localparam int CW = $clog2(K + 1);

    localparam logic [0:0]    c_st_fill = 1'b0;
    localparam logic [0:0]    c_st_done = 1'b1;
    localparam logic [CW-1:0] c_last    = CW'(K - 1);
    localparam logic [AW:0]   c_size    = (AW + 1)'(SIZE);

    logic [0:0]      r_state;
    logic [SIZE-1:0] r_buffer;
    logic [CW-1:0]   r_count;
    logic            r_trunc;

    logic [SIZE-1:0] w_buf_next;
    logic            w_trunc_hit;
    logic [AW:0]     w_pos;

    // Merge the incoming word into the current buffer; offsets are widened by
    // one bit so positions past the top are detected and dropped, never wrapped.
    always_comb begin
        w_buf_next  = r_buffer;
        w_trunc_hit = 1'b0;
        w_pos       = '0;
        for (int j = 0; j < K; j++) begin
            w_pos = {1'b0, bus.in_addr} + (AW + 1)'(j);
            if (w_pos < c_size) begin
                w_buf_next[w_pos[AW-1:0]] = bus.in_data[j];
            end else begin
                w_trunc_hit = 1'b1;
            end
        end
    end

    // Frame FSM: fill with K writes, hold until drained; clear aborts anywhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_st_fill;
            r_buffer <= '0;
            r_count  <= '0;
            r_trunc  <= 1'b0;
        end else if (bus.clear) begin
            r_state  <= c_st_fill;
            r_buffer <= '0;
            r_count  <= '0;
            r_trunc  <= 1'b0;
        end else begin
            case (r_state)
                c_st_fill: begin
                    if (bus.in_valid) begin
                        r_buffer <= w_buf_next;
                        r_trunc  <= r_trunc | w_trunc_hit;
                        r_count  <= r_count + 1'b1;
                        if (r_count == c_last) begin
                            r_state <= c_st_done;
                        end
                    end
                end
                c_st_done: begin
                    if (bus.out_ready) begin
                        r_state  <= c_st_fill;
                        r_buffer <= '0;
                        r_count  <= '0;
                        r_trunc  <= 1'b0;
                    end
                end
                default: r_state <= c_st_fill;
            endcase
        end
    end

    // Handshake flags depend only on the state register.
    assign bus.in_ready    = (r_state == c_st_fill);
    assign bus.out_valid   = (r_state == c_st_done);
    assign bus.buffer_flat = r_buffer;
    assign bus.write_count = r_count;
    assign bus.trunc       = r_trunc;
endmodule
`default_nettype wire

// File: tb/tb_window_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_window_writer
//  Purpose  : Directed self-checking bench for window_writer (SIZE=16, K=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_window_writer;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    window_writer_if #(.SIZE(16), .K(4)) bus ();

    window_writer #(.SIZE(16), .K(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Four back-to-back writes, in_valid held; nibble i of addrs/datas is write i.
    task automatic write_frame(input logic [15:0] addrs, input logic [15:0] datas);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_addr  = addrs[i*4 +: 4];
            bus.in_data  = datas[i*4 +: 4];
            @(posedge clk);
            #1;
            if (i < 3) check("no_early_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_addr   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_in_ready",  {31'd0, bus.in_ready},    32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid},   32'd0);
        check("rst_buffer",    {16'd0, bus.buffer_flat}, 32'd0);
        check("rst_count",     {29'd0, bus.write_count}, 32'd0);
        check("rst_trunc",     {31'd0, bus.trunc},       32'd0);

        // Basic frame
        write_frame(16'hC840, 16'h3F5A);
        check("f1_out_valid", {31'd0, bus.out_valid},   32'd1);
        check("f1_in_ready",  {31'd0, bus.in_ready},    32'd0);
        check("f1_buffer",    {16'd0, bus.buffer_flat}, 32'h3F5A);
        check("f1_trunc",     {31'd0, bus.trunc},       32'd0);
        check("f1_count",     {29'd0, bus.write_count}, 32'd4);
        drain();
        check("f1_drain_buf",   {16'd0, bus.buffer_flat}, 32'd0);
        check("f1_drain_valid", {31'd0, bus.out_valid},   32'd0);
        check("f1_drain_ready", {31'd0, bus.in_ready},    32'd1);
        check("f1_drain_count", {29'd0, bus.write_count}, 32'd0);

        // Truncation at the top, no wrap
        write_frame(16'h000E, 16'h000F);
        check("f2_buffer", {16'd0, bus.buffer_flat}, 32'hC000);
        check("f2_trunc",  {31'd0, bus.trunc},       32'd1);
        drain();
        check("f2_drain_trunc", {31'd0, bus.trunc}, 32'd0);

        // Overlapping writes
        write_frame(16'h8820, 16'h210F);
        check("f3_buffer", {16'd0, bus.buffer_flat}, 32'h0203);
        check("f3_trunc",  {31'd0, bus.trunc},       32'd0);
        drain();

        // Backpressure: writes ignored while frame waits
        write_frame(16'hC840, 16'h4321);
        bus.in_valid = 1'b1;
        bus.in_addr  = 4'd0;
        bus.in_data  = 4'hF;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", {31'd0, bus.in_ready},    32'd0);
            check("bp_buffer",   {16'd0, bus.buffer_flat}, 32'h4321);
        end
        bus.in_valid = 1'b0;
        check("bp_count", {29'd0, bus.write_count}, 32'd4);
        drain();
        write_frame(16'hC840, 16'h0009);
        check("bp_next_buffer", {16'd0, bus.buffer_flat}, 32'h0009);
        check("bp_next_trunc",  {31'd0, bus.trunc},       32'd0);
        drain();

        // Clear mid-frame, with a simultaneous write that must be discarded
        bus.in_valid = 1'b1;
        bus.in_addr  = 4'd0;
        bus.in_data  = 4'hA;
        @(posedge clk);
        #1;
        bus.in_addr  = 4'd4;
        bus.in_data  = 4'hB;
        @(posedge clk);
        #1;
        check("clr_pre_count", {29'd0, bus.write_count}, 32'd2);
        check("clr_pre_buf",   {16'd0, bus.buffer_flat}, 32'h00BA);
        bus.in_addr  = 4'd8;
        bus.in_data  = 4'hC;
        bus.clear    = 1'b1;
        @(posedge clk);
        #1;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_buf",   {16'd0, bus.buffer_flat}, 32'd0);
        check("clr_count", {29'd0, bus.write_count}, 32'd0);
        check("clr_ready", {31'd0, bus.in_ready},    32'd1);
        write_frame(16'h0C84, 16'h3217);
        check("clr_frame_buf",   {16'd0, bus.buffer_flat}, 32'h2173);
        check("clr_frame_valid", {31'd0, bus.out_valid},   32'd1);
        drain();

        // Asynchronous reset while a frame waits in DONE
        write_frame(16'hC840, 16'h8765);
        check("ar_pre_buf", {16'd0, bus.buffer_flat}, 32'h8765);
        #2;
        rst = 1'b1;
        #1;
        check("ar_out_valid", {31'd0, bus.out_valid},   32'd0);
        check("ar_buffer",    {16'd0, bus.buffer_flat}, 32'd0);
        check("ar_count",     {29'd0, bus.write_count}, 32'd0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ar_in_ready", {31'd0, bus.in_ready}, 32'd1);
        write_frame(16'hC840, 16'h1111);
        check("ar_frame_buf",   {16'd0, bus.buffer_flat}, 32'h1111);
        check("ar_frame_valid", {31'd0, bus.out_valid},   32'd1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
